// File: rtl/dff_obs_serializer.sv
// Observation serializer: snapshots a parallel DFF output vector on a capture
// pulse and streams it out as a framed serial bit stream (header, LSB-first data,
// CRC-8) over a single-bit valid/ready link.
module dff_obs_serializer #(
  parameter int unsigned WIDTH    = 64,
  parameter logic [7:0]  HDR      = 8'hA5,
  parameter logic [7:0]  CRC_POLY = 8'h07
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] obs,
  input  logic             cap,
  output logic             busy,
  output logic             tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic [7:0]       frame_cnt,
  output logic             ovr
);

  // Counter must index both the 8-beat phases and the WIDTH-beat data phase.
  localparam int unsigned CntW = $clog2(WIDTH + 8);
  localparam logic [CntW-1:0] CntLast8    = CntW'(7);
  localparam logic [CntW-1:0] CntLastData = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StHeader, StData, StCrc} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             ovr_q, ovr_d;
  logic             beat;
  logic             fb;

  // Output decode: everything is a function of registered state, so holding the
  // state during a stall keeps tx_data/tx_last stable.
  always_comb begin
    busy     = (state_q != StIdle);
    tx_valid = busy;
    beat     = tx_valid & tx_ready;
    tx_last  = (state_q == StCrc) && (cnt_q == CntLast8);
    tx_data  = 1'b0;
    case (state_q)
      StHeader: tx_data = HDR[~cnt_q[2:0]];    // cnt 0..7 -> bit 7..0
      StData:   tx_data = shadow_q[0];         // shadow shifts right each beat
      StCrc:    tx_data = crc_q[~cnt_q[2:0]];
      default:  tx_data = 1'b0;
    endcase
  end

  // Next-state logic: phases and counter advance only on a completed beat.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    crc_d       = crc_q;
    frame_cnt_d = frame_cnt_q;
    ovr_d       = ovr_q;
    fb          = crc_q[7] ^ shadow_q[0];

    // A capture request while a frame is running is dropped but remembered.
    if (cap && (state_q != StIdle)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (cap) begin
          shadow_d = obs;
          crc_d    = 8'h00;
          ovr_d    = 1'b0;
          cnt_d    = '0;
          state_d  = StHeader;
        end
      end
      StHeader: begin
        if (beat) begin
          if (cnt_q == CntLast8) begin
            cnt_d   = '0;
            state_d = StData;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (beat) begin
          shadow_d = shadow_q >> 1;
          crc_d    = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
          if (cnt_q == CntLastData) begin
            cnt_d   = '0;
            state_d = StCrc;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StCrc: begin
        if (beat) begin
          if (cnt_q == CntLast8) begin
            cnt_d       = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shadow_q    <= '0;
      crc_q       <= 8'h00;
      frame_cnt_q <= 8'h00;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      crc_q       <= crc_d;
      frame_cnt_q <= frame_cnt_d;
      ovr_q       <= ovr_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_dff_obs_serializer.sv
// Directed bench for dff_obs_serializer: framing, CRC, stalls, overrun,
// mid-frame reset and frame counter wrap.
module tb_dff_obs_serializer;

  localparam logic [7:0] Hdr  = 8'hA5;
  localparam logic [7:0] Poly = 8'h07;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] obs;
  logic        cap;
  logic        busy, tx_data, tx_valid, tx_ready, tx_last, ovr;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  dff_obs_serializer #(
    .WIDTH    (64),
    .HDR      (Hdr),
    .CRC_POLY (Poly)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .obs       (obs),
    .cap       (cap),
    .busy      (busy),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_last   (tx_last),
    .frame_cnt (frame_cnt),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Bit-serial CRC-8 over the data bits, LSB first, init 0.
  function automatic logic [7:0] crc_of(input logic [63:0] d);
    logic [7:0] c;
    logic       f;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      f = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (f ? Poly : 8'h00);
    end
    return c;
  endfunction

  // Expected frame, bit i = beat i.
  function automatic logic [79:0] exp_frame(input logic [63:0] d);
    logic [7:0]  c;
    logic [79:0] f;
    c = crc_of(d);
    f = '0;
    for (int i = 0; i < 8; i++) begin
      f[i]      = Hdr[7-i];
      f[72 + i] = c[7-i];
    end
    for (int i = 0; i < 64; i++) f[8 + i] = d[i];
    return f;
  endfunction

  // Start a frame with a cap pulse and collect all 80 beats.
  task automatic run_frame(input logic [63:0] o, input bit rnd, input bit mid_obs,
                           input int cap_beat, output logic [79:0] bits,
                           output logic [79:0] lasts, output int busy_cyc);
    int   beat;
    int   cyc;
    bit   stalled;
    bit   capped;
    logic pd, pl;
    bits = '0; lasts = '0; busy_cyc = 0; beat = 0; cyc = 0;
    stalled = 0; capped = 0; pd = 0; pl = 0;
    obs = o;
    cap = 1'b1;
    @(posedge clk); #1;
    cap = 1'b0;
    while (beat < 80 && cyc < 2000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_obs && beat == 20) obs = ~o;
      if (!capped && beat == cap_beat) begin
        cap    = 1'b1;
        capped = 1;
      end
      @(negedge clk);
      if (busy) busy_cyc++;
      if (stalled) check("stall_hold", {78'b0, tx_data, tx_last}, {78'b0, pd, pl});
      if (tx_valid && tx_ready) begin
        bits[beat]  = tx_data;
        lasts[beat] = tx_last;
        beat++;
        stalled = 0;
      end else begin
        stalled = tx_valid;
        pd      = tx_data;
        pl      = tx_last;
      end
      @(posedge clk); #1;
      cap = 1'b0;
      cyc++;
    end
    check("frame_beats_done", 80'(beat), 80'd80);
  endtask

  logic [79:0] bits, lasts;
  logic [79:0] last_onehot;
  logic [63:0] v;
  int          bc;

  initial begin
    last_onehot = {1'b1, 79'b0};
    rst_n = 1'b0; cap = 1'b0; obs = '0; tx_ready = 1'b0;
    #12;
    check("reset_outputs", {74'b0, busy, tx_valid, tx_data, tx_last, ovr, frame_cnt[0]},
          80'd0);
    check("reset_frame_cnt", {72'b0, frame_cnt}, 80'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: all-zero vector, ready always high
    run_frame(64'h0, 0, 0, -1, bits, lasts, bc);
    check("t1_frame_hand", bits, 80'hA5);
    check("t1_frame_model", bits, exp_frame(64'h0));
    check("t1_last", lasts, last_onehot);
    check("t1_busy_cycles", 80'(bc), 80'd80);
    check("t1_frame_cnt", {72'b0, frame_cnt}, 80'd1);
    check("t1_idle_after", {78'b0, busy, tx_valid}, 80'd0);

    // 2: single set bit, first data beat
    run_frame(64'h1, 0, 0, -1, bits, lasts, bc);
    check("t2_data_bit0", {79'b0, bits[8]}, 80'd1);
    check("t2_data_rest", {17'b0, bits[71:9]}, 80'd0);
    check("t2_frame_model", bits, exp_frame(64'h1));
    check("t2_frame_cnt", {72'b0, frame_cnt}, 80'd2);

    // 3: random stalls, obs changed mid-frame
    v = 64'hDEAD_BEEF_0123_4567;
    run_frame(v, 1, 1, -1, bits, lasts, bc);
    check("t3_frame_model", bits, exp_frame(v));
    check("t3_last", lasts, last_onehot);
    check("t3_frame_cnt", {72'b0, frame_cnt}, 80'd3);

    // 4: cap while busy sets ovr and leaves the frame intact
    v = 64'hF0F0_0000_FFFF_1234;
    run_frame(v, 0, 0, 10, bits, lasts, bc);
    check("t4_frame_model", bits, exp_frame(v));
    check("t4_ovr_set", {79'b0, ovr}, 80'd1);
    check("t4_frame_cnt", {72'b0, frame_cnt}, 80'd4);
    // cap on the final beat's edge is ignored: no new frame starts
    run_frame(64'h5, 0, 0, 79, bits, lasts, bc);
    check("t4_last_beat_cap_frame", bits, exp_frame(64'h5));
    check("t4_last_beat_cap_idle", {79'b0, busy}, 80'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_ovr_sticky", {78'b0, ovr, busy}, 80'd2);
    v = 64'h8000_0000_0000_0003;
    run_frame(v, 0, 0, -1, bits, lasts, bc);
    check("t4_ovr_cleared", {79'b0, ovr}, 80'd0);
    check("t4_frame2_model", bits, exp_frame(v));
    check("t4_frame_cnt2", {72'b0, frame_cnt}, 80'd6);

    // 5: reset at data beat 30 (frame beat 38)
    v = 64'h0123_4567_89AB_CDEF;
    obs = v; tx_ready = 1'b1; cap = 1'b1;
    @(posedge clk); #1;
    cap = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    check("t5_mid_data", {78'b0, tx_valid, tx_data}, {78'b0, 1'b1, v[30]});
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", {72'b0, busy, tx_valid, tx_data, tx_last, ovr, 3'b0},
          80'd0);
    check("t5_reset_frame_cnt", {72'b0, frame_cnt}, 80'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_no_resume", {78'b0, busy, tx_valid}, 80'd0);
    run_frame(v, 0, 0, -1, bits, lasts, bc);
    check("t5_frame_model", bits, exp_frame(v));
    check("t5_frame_cnt", {72'b0, frame_cnt}, 80'd1);

    // 6: back-to-back frames until frame_cnt wraps
    for (int i = 0; i < 255; i++) begin
      v = {$urandom, $urandom};
      run_frame(v, 0, 0, -1, bits, lasts, bc);
      check("t6_frame_model", bits, exp_frame(v));
      check("t6_frame_cnt", {72'b0, frame_cnt}, 80'((i + 2) % 256));
    end
    check("t6_wrap", {72'b0, frame_cnt}, 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
